// File: rtl/denormalize_pkg.sv
// Shared constants and helpers for the normalize/denormalize pair.
// The input-side normalizer imports the same widths and scale factors.
package denormalize_pkg;

    localparam int unsigned NORM_W = 18;
    localparam int unsigned MULT_W = 16;
    localparam int unsigned PROD_W = NORM_W + MULT_W;
    localparam int unsigned OUT_W  = 32;

    localparam int unsigned DENORM_MULT_DEF  = 32781;
    localparam int unsigned DENORM_SHIFT_DEF = 6;
    localparam int unsigned OFFSET_DEF       = 262143;

    typedef logic [NORM_W-1:0] norm_t;
    typedef logic [PROD_W-1:0] prod_t;
    typedef logic [OUT_W-1:0]  denorm_t;

    // Scaled product minus offset. The 32-bit wrap-around equals the
    // 34-bit signed difference truncated to 32 bits.
    function automatic denorm_t scale_out(
        input prod_t       prod,
        input int unsigned shift,
        input int unsigned offset
    );
        prod_t shifted;
        shifted = prod >> shift;
        return OUT_W'(shifted) - OUT_W'(offset);
    endfunction

endpackage

// File: rtl/denormalize_if.sv
// Stream bundle around the denormalizer: normalized input, denormalized
// output and the completed-sample counter.
interface denormalize_if #(
    parameter int unsigned CNT_W = 16
);
    import denormalize_pkg::*;

    norm_t             in_V;
    logic              in_vld;
    logic              in_rdy;
    denorm_t           out_V;
    logic              out_vld;
    logic              out_rdy;
    logic [CNT_W-1:0]  sample_cnt;

    // Producer/consumer side driving the block.
    modport master (
        output in_V,
        output in_vld,
        input  in_rdy,
        input  out_V,
        input  out_vld,
        output out_rdy,
        input  sample_cnt
    );

    // The denormalizer itself.
    modport slave (
        input  in_V,
        input  in_vld,
        output in_rdy,
        output out_V,
        output out_vld,
        input  out_rdy,
        output sample_cnt
    );

endinterface

// File: rtl/denorm_stage.sv
// One pipeline register: valid bit plus data word, advanced only when enabled.
module denorm_stage #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         vld_d,
    input  logic [W-1:0] d,
    output logic         vld_q,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            q     <= '0;
        end else if (en) begin
            vld_q <= vld_d;
            q     <= d;
        end
    end

endmodule

// File: rtl/denormalize.sv
// Three-stage denormalizer: capture, multiply by inverse scale, shift and
// remove offset. A single global stall freezes the whole pipe.
module denormalize
    import denormalize_pkg::*;
#(
    parameter int unsigned DENORM_MULT  = DENORM_MULT_DEF,
    parameter int unsigned DENORM_SHIFT = DENORM_SHIFT_DEF,
    parameter int unsigned OFFSET       = OFFSET_DEF,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic [NORM_W-1:0] in_V,
    input  logic              in_vld,
    output logic              in_rdy,
    output logic [OUT_W-1:0]  out_V,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [CNT_W-1:0]  sample_cnt
);

    localparam logic [MULT_W-1:0] MULT_K = MULT_W'(DENORM_MULT);

    logic    stall;
    logic    advance;

    logic    s1_vld;
    norm_t   s1_q;
    prod_t   s2_d;
    logic    s2_vld;
    prod_t   s2_q;
    denorm_t s3_d;

    assign stall   = out_vld && !out_rdy;
    assign advance = !stall;
    assign in_rdy  = !stall;

    // A bubble is loaded whenever the pipe advances without a valid input.
    denorm_stage #(
        .W (NORM_W)
    ) u_s1 (
        .clk   (ap_clk),
        .rst   (ap_rst),
        .en    (advance),
        .vld_d (in_vld),
        .d     (in_V),
        .vld_q (s1_vld),
        .q     (s1_q)
    );

    always_comb begin
        s2_d = PROD_W'(s1_q) * PROD_W'(MULT_K);
    end

    denorm_stage #(
        .W (PROD_W)
    ) u_s2 (
        .clk   (ap_clk),
        .rst   (ap_rst),
        .en    (advance),
        .vld_d (s1_vld),
        .d     (s2_d),
        .vld_q (s2_vld),
        .q     (s2_q)
    );

    always_comb begin
        s3_d = scale_out(s2_q, DENORM_SHIFT, OFFSET);
    end

    denorm_stage #(
        .W (OUT_W)
    ) u_s3 (
        .clk   (ap_clk),
        .rst   (ap_rst),
        .en    (advance),
        .vld_d (s2_vld),
        .d     (s3_d),
        .vld_q (out_vld),
        .q     (out_V)
    );

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            sample_cnt <= '0;
        end else if (out_vld && out_rdy) begin
            sample_cnt <= sample_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_denormalize.sv
// Directed bench for denormalize: inputs change and outputs are sampled on the
// falling edge, so every handshake happens on the following rising edge.
module tb_denormalize;
    import denormalize_pkg::*;

    logic ap_clk = 1'b0;
    logic ap_rst;
    int   total = 0;
    int   bad   = 0;

    denormalize_if #(.CNT_W(16)) bus ();

    denormalize #(
        .DENORM_MULT  (32781),
        .DENORM_SHIFT (6),
        .OFFSET       (262143),
        .CNT_W        (16)
    ) dut (
        .ap_clk     (ap_clk),
        .ap_rst     (ap_rst),
        .in_V       (bus.in_V),
        .in_vld     (bus.in_vld),
        .in_rdy     (bus.in_rdy),
        .out_V      (bus.out_V),
        .out_vld    (bus.out_vld),
        .out_rdy    (bus.out_rdy),
        .sample_cnt (bus.sample_cnt)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic pulse_reset();
        @(negedge ap_clk);
        bus.in_vld  = 1'b0;
        bus.out_rdy = 1'b1;
        ap_rst = 1'b1;
        #2;
        ap_rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_vld  = 1'b0;
        bus.in_V    = '0;
        bus.out_rdy = 1'b1;
        ap_rst      = 1'b1;
        #1;
        total++;
        if (bus.in_rdy !== 1'b1) begin
            bad++; $display("FAIL reset_in_rdy_async: got %0b want 1", bus.in_rdy);
        end
        repeat (2) @(negedge ap_clk);
        total++;
        if (bus.out_vld !== 1'b0) begin
            bad++; $display("FAIL reset_out_vld: got %0b want 0", bus.out_vld);
        end
        total++;
        if (bus.out_V !== 32'd0) begin
            bad++; $display("FAIL reset_out_V: got %0d want 0", $signed(bus.out_V));
        end
        total++;
        if (bus.sample_cnt !== 16'd0) begin
            bad++; $display("FAIL reset_sample_cnt: got %0d want 0", bus.sample_cnt);
        end
        total++;
        if (bus.in_rdy !== 1'b1) begin
            bad++; $display("FAIL reset_in_rdy: got %0b want 1", bus.in_rdy);
        end
        ap_rst = 1'b0;
    endtask

    // in_V=0 accepted at one rising edge; out_vld seen on the third falling edge after it.
    task automatic test_latency();
        logic [31:0] want;
        want = -262143;
        @(negedge ap_clk);
        bus.in_V    = '0;
        bus.in_vld  = 1'b1;
        bus.out_rdy = 1'b1;
        @(negedge ap_clk);
        bus.in_vld = 1'b0;
        total++;
        if (bus.out_vld !== 1'b0) begin
            bad++; $display("FAIL latency_cycle1: got out_vld=%0b want 0", bus.out_vld);
        end
        @(negedge ap_clk);
        total++;
        if (bus.out_vld !== 1'b0) begin
            bad++; $display("FAIL latency_cycle2: got out_vld=%0b want 0", bus.out_vld);
        end
        @(negedge ap_clk);
        total++;
        if (bus.out_vld !== 1'b1 || bus.out_V !== want) begin
            bad++; $display("FAIL latency_cycle3: got vld=%0b V=%0d want vld=1 V=-262143",
                            bus.out_vld, $signed(bus.out_V));
        end
        @(negedge ap_clk);
        total++;
        if (bus.out_vld !== 1'b0) begin
            bad++; $display("FAIL latency_single: got out_vld=%0b want 0", bus.out_vld);
        end
    endtask

    task automatic test_values();
        logic [31:0] want [2];
        int k;
        want[0] = 32'd105;
        want[1] = 32'd134008320;
        k = 0;
        @(negedge ap_clk);
        bus.in_V   = 18'd512;
        bus.in_vld = 1'b1;
        @(negedge ap_clk);
        bus.in_V   = 18'd262143;
        @(negedge ap_clk);
        bus.in_vld = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (bus.out_vld === 1'b1) begin
                total++;
                if (k >= 2 || bus.out_V !== want[k]) begin
                    bad++; $display("FAIL values_out%0d: got %0d want %0d", k,
                                    $signed(bus.out_V), (k < 2) ? $signed(want[k]) : 0);
                end
                k++;
            end
            @(negedge ap_clk);
        end
        total++;
        if (k != 2) begin
            bad++; $display("FAIL values_count: got %0d want 2", k);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] want [10];
        int k;
        int first_c;
        want[0] = -262143; want[1] = -261631; want[2] = -261119; want[3] = -260607;
        want[4] = -260095; want[5] = -259582; want[6] = -259070; want[7] = -258558;
        want[8] = -258046; want[9] = -257534;
        k = 0;
        first_c = -1;
        pulse_reset();
        for (int c = 0; c < 30; c++) begin
            @(negedge ap_clk);
            if (bus.out_vld === 1'b1) begin
                if (first_c < 0) first_c = c;
                total++;
                if (k >= 10 || bus.out_V !== want[k] || c != first_c + k) begin
                    bad++; $display("FAIL b2b_out%0d: got %0d at cycle %0d want %0d at cycle %0d",
                                    k, $signed(bus.out_V), c,
                                    (k < 10) ? $signed(want[k]) : 0, first_c + k);
                end
                k++;
            end
            if (c < 10) begin
                bus.in_V   = 18'(c);
                bus.in_vld = 1'b1;
            end else begin
                bus.in_vld = 1'b0;
            end
        end
        total++;
        if (k != 10) begin
            bad++; $display("FAIL b2b_count: got %0d want 10", k);
        end
        total++;
        if (bus.sample_cnt !== 16'd10) begin
            bad++; $display("FAIL b2b_sample_cnt: got %0d want 10", bus.sample_cnt);
        end
    endtask

    task automatic test_reset_inflight();
        int stale;
        stale = 0;
        bus.out_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge ap_clk);
            bus.in_V   = 18'(7 + i);
            bus.in_vld = 1'b1;
        end
        @(negedge ap_clk);
        bus.in_vld = 1'b0;
        total++;
        if (bus.out_vld !== 1'b1) begin
            bad++; $display("FAIL inflight_pre_vld: got %0b want 1", bus.out_vld);
        end
        ap_rst = 1'b1;
        #1;
        total++;
        if (bus.out_vld !== 1'b0) begin
            bad++; $display("FAIL inflight_rst_vld: got %0b want 0", bus.out_vld);
        end
        total++;
        if (bus.sample_cnt !== 16'd0) begin
            bad++; $display("FAIL inflight_rst_cnt: got %0d want 0", bus.sample_cnt);
        end
        @(negedge ap_clk);
        ap_rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge ap_clk);
            if (bus.out_vld !== 1'b0) stale++;
        end
        total++;
        if (stale != 0) begin
            bad++; $display("FAIL inflight_stale: got %0d stale outputs want 0", stale);
        end
        bus.in_V   = 18'd512;
        bus.in_vld = 1'b1;
        @(negedge ap_clk);
        bus.in_vld = 1'b0;
        @(negedge ap_clk);
        total++;
        if (bus.out_vld !== 1'b0) begin
            bad++; $display("FAIL inflight_post_early: got out_vld=%0b want 0", bus.out_vld);
        end
        @(negedge ap_clk);
        total++;
        if (bus.out_vld !== 1'b1 || bus.out_V !== 32'd105) begin
            bad++; $display("FAIL inflight_post: got vld=%0b V=%0d want vld=1 V=105",
                            bus.out_vld, $signed(bus.out_V));
        end
        @(negedge ap_clk);
    endtask

    task automatic test_stall();
        logic [17:0] vin  [6];
        logic [31:0] want [6];
        logic [31:0] held;
        logic        stalled;
        logic        prev_stalled;
        int idx;
        int k;
        int stall_cycles;
        vin[0] = 18'd512; vin[1] = 18'd262143; vin[2] = 18'd0;
        vin[3] = 18'd1;   vin[4] = 18'd2;      vin[5] = 18'd3;
        want[0] = 32'd105; want[1] = 32'd134008320; want[2] = -262143;
        want[3] = -261631; want[4] = -261119;       want[5] = -260607;
        idx = 0; k = 0; stall_cycles = 0;
        prev_stalled = 1'b0;
        held = '0;
        pulse_reset();
        for (int c = 0; c < 40; c++) begin
            @(negedge ap_clk);
            if (prev_stalled) begin
                total++;
                if (bus.out_vld !== 1'b1 || bus.out_V !== held) begin
                    bad++; $display("FAIL stall_hold: got vld=%0b V=%0d want vld=1 V=%0d",
                                    bus.out_vld, $signed(bus.out_V), $signed(held));
                end
            end
            bus.out_rdy = !(c >= 4 && c < 8);
            if (idx < 6) begin
                bus.in_V   = vin[idx];
                bus.in_vld = 1'b1;
            end else begin
                bus.in_vld = 1'b0;
            end
            #1;
            stalled = bus.out_vld && !bus.out_rdy;
            if (stalled) begin
                stall_cycles++;
                held = bus.out_V;
                total++;
                if (bus.in_rdy !== 1'b0) begin
                    bad++; $display("FAIL stall_in_rdy: got %0b want 0", bus.in_rdy);
                end
            end
            if (bus.out_vld === 1'b1 && bus.out_rdy === 1'b1) begin
                total++;
                if (k >= 6 || bus.out_V !== want[k]) begin
                    bad++; $display("FAIL stall_out%0d: got %0d want %0d", k,
                                    $signed(bus.out_V), (k < 6) ? $signed(want[k]) : 0);
                end
                k++;
            end
            if (bus.in_vld === 1'b1 && bus.in_rdy === 1'b1) idx++;
            prev_stalled = stalled;
        end
        bus.in_vld  = 1'b0;
        bus.out_rdy = 1'b1;
        total++;
        if (k != 6) begin
            bad++; $display("FAIL stall_count: got %0d want 6", k);
        end
        total++;
        if (stall_cycles != 4) begin
            bad++; $display("FAIL stall_cycles: got %0d want 4", stall_cycles);
        end
    endtask

    task automatic test_wrap();
        int  done;
        logic chk1;
        logic chk2;
        done = 0; chk1 = 1'b0; chk2 = 1'b0;
        pulse_reset();
        bus.in_V   = 18'd5;
        bus.in_vld = 1'b1;
        for (int c = 0; c < 70000; c++) begin
            @(negedge ap_clk);
            if (done == 65535 && !chk1) begin
                chk1 = 1'b1;
                total++;
                if (bus.sample_cnt !== 16'd65535) begin
                    bad++; $display("FAIL wrap_max: got %0d want 65535", bus.sample_cnt);
                end
            end
            if (done == 65536) begin
                chk2 = 1'b1;
                total++;
                if (bus.sample_cnt !== 16'd0) begin
                    bad++; $display("FAIL wrap_zero: got %0d want 0", bus.sample_cnt);
                end
                break;
            end
            if (bus.out_vld === 1'b1 && bus.out_rdy === 1'b1) done++;
        end
        bus.in_vld = 1'b0;
        if (!chk2) begin
            total++; bad++;
            $display("FAIL wrap_timeout: got %0d handshakes want 65536", done);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_values();
        test_back_to_back();
        test_reset_inflight();
        test_stall();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/denormalize.md
DENORMALIZE -- requirements
Module: denormalize

Interface
REQ-001 The module SHALL have parameter DENORM_MULT, default 32781, unsigned 16-bit inverse-scale multiplier.
REQ-002 The module SHALL have parameter DENORM_SHIFT, default 6, right-shift applied to the product.
REQ-003 The module SHALL have parameter OFFSET, default 262143, subtracted after scaling (undoes the input-side offset).
REQ-004 The module SHALL have parameter CNT_W, default 16, width of the sample counter.
REQ-005 The module SHALL have port ap_clk  input  1  single clock; all state changes on its rising edge.
REQ-006 The module SHALL have port ap_rst  input  1  reset, asynchronous, active-high.
REQ-007 The module SHALL have port in_V  input  18  unsigned normalized network output (ap_fixed raw bits).
REQ-008 The module SHALL have port in_vld  input  1  in_V valid.
REQ-009 The module SHALL have port in_rdy  output  1  module accepts in_V this cycle.
REQ-010 The module SHALL have port out_V  output  32  signed denormalized raw value.
REQ-011 The module SHALL have port out_vld  output  1  out_V valid.
REQ-012 The module SHALL have port out_rdy  input  1  downstream accepts out_V.
REQ-013 The module SHALL have port sample_cnt  output  CNT_W  count of completed output handshakes.

Function
REQ-014 Input handshake SHALL occur when in_vld && in_rdy are high at a rising edge; output handshake SHALL occur when out_vld && out_rdy are high.
REQ-015 Datapath SHALL be 3 registered stages: S1 capture in_V; S2 product = in_V * DENORM_MULT (34-bit unsigned); S3 out_V = signed(product >> DENORM_SHIFT) - OFFSET, computed at 34 bits and truncated to 32.
REQ-016 Each stage SHALL carry a valid bit; data in a stage with its valid bit low is don't-care.
REQ-017 Global stall = out_vld && !out_rdy; during a stall all stages and valid bits SHALL hold; otherwise all stages SHALL advance one step.
REQ-018 in_rdy SHALL equal !stall (combinational from out_vld and out_rdy).
REQ-019 With out_rdy held high, out_vld SHALL rise exactly 3 cycles after the input handshake; throughput SHALL be one sample per cycle.
REQ-020 Bubbles (in_vld low) SHALL propagate as invalid stages; output order SHALL equal input order; no sample SHALL be dropped or duplicated.
REQ-021 out_V and out_vld SHALL remain stable while out_vld && !out_rdy.
REQ-022 sample_cnt SHALL increment by 1 on each output handshake and wrap from 2^CNT_W-1 to 0.
REQ-023 Simultaneous input and output handshakes in the same cycle SHALL both complete (full-pipe streaming).
REQ-024 No saturation is required: for all 18-bit inputs the result SHALL fit in signed 32 bits (range -262143 .. 134008320 at defaults).

Reset
REQ-025 Asserting ap_rst SHALL immediately clear all stage valid bits, out_vld and sample_cnt to 0, independent of ap_clk.
REQ-026 out_V SHALL reset to 0; in_rdy SHALL read 1 while in reset.
REQ-027 Reset mid-operation SHALL discard all in-flight samples; the first post-reset accepted sample SHALL see the full 3-cycle latency.

Structure
REQ-028 DENORM_MULT, DENORM_SHIFT, OFFSET defaults and the 18-bit normalized width constant SHALL live in a shared package also used by the input-side normalizer.
REQ-029 One sub-module, denorm_stage, SHALL implement a single valid+data pipeline register with hold enable, instantiated per stage.

Verification
REQ-030 Reset, then in_V=0 with out_rdy=1 -> out_V=-262143 with out_vld high 3 cycles after acceptance.
REQ-031 in_V=512 -> out_V=105; in_V=262143 -> out_V=134008320.
REQ-032 Back-to-back stream 0,1,2,...,9 with out_rdy=1 -> 10 consecutive valid outputs in order, sample_cnt=10.
REQ-033 Stream of 6 samples with out_rdy low for 4 cycles mid-stream -> in_rdy low during stall, out_V stable, no loss or duplication, order preserved.
REQ-034 Assert ap_rst with 3 samples in flight -> out_vld and sample_cnt immediately 0; no stale output after release.
REQ-035 Force sample_cnt to 65535 (CNT_W=16) via 65535 handshakes, then one more -> sample_cnt=0.
